// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb_if
// Purpose  : Write-back, read and issue signals of the scoreboarded register file.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_sb_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2
);
    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic                   we;
    logic [c_AW-1:0]        wa;
    logic [WIDTH-1:0]       wd;
    logic [NREAD*c_AW-1:0]  ra;
    logic [NREAD*WIDTH-1:0] rd;
    logic [NREAD-1:0]       rd_busy;
    logic                   iss_en;
    logic [c_AW-1:0]        iss_addr;
    logic [c_CW-1:0]        busy_cnt;

    modport master (
        output we, wa, wd, ra, iss_en, iss_addr,
        input  rd, rd_busy, busy_cnt
    );

    modport slave (
        input  we, wa, wd, ra, iss_en, iss_addr,
        output rd, rd_busy, busy_cnt
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_sb
// Purpose  : Multi-port register file with write-through bypass and busy scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input wire logic     clk,
    input wire logic     reset,
    reg_file_sb_if.slave bus
);
    localparam int c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW     = $clog2(DEPTH + 1);
    localparam bit c_ZERO   = (ZERO_REG != 0);
    localparam bit c_BYPASS = (BYPASS != 0);

    logic [WIDTH-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [c_CW-1:0]  r_busy_cnt;

    logic w_wr;
    logic w_set;
    logic w_inc;
    logic w_dec;

    assign w_wr  = bus.we && !(c_ZERO && (bus.wa == '0));
    assign w_set = bus.iss_en && !(c_ZERO && (bus.iss_addr == '0));
    // A same-register clear+set leaves the bit set, so it never counts as a decrement.
    assign w_inc = w_set && !r_busy[bus.iss_addr];
    assign w_dec = bus.we && r_busy[bus.wa] && !(w_set && (bus.iss_addr == bus.wa));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_rf[bus.wa] <= bus.wd;
            end
            if (bus.we) begin
                r_busy[bus.wa] <= 1'b0;
            end
            // Later assignment wins, so a new producer overrides the write-back clear.
            if (w_set) begin
                r_busy[bus.iss_addr] <= 1'b1;
            end
            if (w_inc && !w_dec) begin
                r_busy_cnt <= r_busy_cnt + c_CW'(1);
            end else if (w_dec && !w_inc) begin
                r_busy_cnt <= r_busy_cnt - c_CW'(1);
            end
        end
    end

    assign bus.busy_cnt = r_busy_cnt;

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [c_AW-1:0] w_ra;
        logic            w_zero;
        logic            w_fwd;

        assign w_ra   = bus.ra[gi*c_AW +: c_AW];
        assign w_zero = c_ZERO && (w_ra == '0);
        assign w_fwd  = c_BYPASS && bus.we && (bus.wa == w_ra);

        assign bus.rd[gi*WIDTH +: WIDTH] = w_zero ? '0 :
                                           w_fwd  ? bus.wd :
                                                    r_rf[w_ra];
        assign bus.rd_busy[gi] = !w_zero && !w_fwd && r_busy[w_ra];
    end
endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_sb
// Purpose  : Scoreboard bench for reg_file_sb, with and without bypass.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;
    localparam int c_W  = 32;
    localparam int c_D  = 32;
    localparam int c_NR = 2;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  rb;
        logic [5:0]  cnt;
        logic [63:0] rd_nb;
        logic [1:0]  rb_nb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ra;
    logic        iss_en;
    logic [4:0]  iss_addr;

    int checks   = 0;
    int failures = 0;

    exp_t q[$];

    logic [31:0] m_rf [32];
    bit          m_busy [32];

    reg_file_sb_if #(.WIDTH(c_W), .DEPTH(c_D), .NREAD(c_NR)) bus ();
    reg_file_sb_if #(.WIDTH(c_W), .DEPTH(c_D), .NREAD(c_NR)) bus_nb ();

    assign bus.we          = we;
    assign bus.wa          = wa;
    assign bus.wd          = wd;
    assign bus.ra          = ra;
    assign bus.iss_en      = iss_en;
    assign bus.iss_addr    = iss_addr;
    assign bus_nb.we       = we;
    assign bus_nb.wa       = wa;
    assign bus_nb.wd       = wd;
    assign bus_nb.ra       = ra;
    assign bus_nb.iss_en   = iss_en;
    assign bus_nb.iss_addr = iss_addr;

    reg_file_sb #(.WIDTH(c_W), .DEPTH(c_D), .NREAD(c_NR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    reg_file_sb #(.WIDTH(c_W), .DEPTH(c_D), .NREAD(c_NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference read: register 0 is hardwired, forwarding only when bypass is on.
    function automatic logic [31:0] ref_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0)               return 32'd0;
        if (byp && we && (wa == a))  return wd;
        return m_rf[a];
    endfunction

    function automatic logic ref_busy(input logic [4:0] a, input bit byp);
        if (a == 5'd0)               return 1'b0;
        if (byp && we && (wa == a))  return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic [5:0] ref_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return 6'(n);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic cyc(input bit rst_i, input bit we_i, input logic [4:0] wa_i,
                       input logic [31:0] wd_i, input logic [4:0] ra0, input logic [4:0] ra1,
                       input bit iss_i, input logic [4:0] ia_i, input bit chk);
        exp_t e;
        reset    = rst_i;
        we       = we_i;
        wa       = wa_i;
        wd       = wd_i;
        ra       = {ra1, ra0};
        iss_en   = iss_i;
        iss_addr = ia_i;
        if (chk) begin
            e.rd    = {ref_rd(ra1, 1'b1), ref_rd(ra0, 1'b1)};
            e.rb    = {ref_busy(ra1, 1'b1), ref_busy(ra0, 1'b1)};
            e.cnt   = ref_cnt();
            e.rd_nb = {ref_rd(ra1, 1'b0), ref_rd(ra0, 1'b0)};
            e.rb_nb = {ref_busy(ra1, 1'b0), ref_busy(ra0, 1'b0)};
            q.push_back(e);
        end
        @(posedge clk);
        if (rst_i) begin
            model_clear();
        end else begin
            if (we_i && wa_i != 5'd0) m_rf[wa_i] = wd_i;
            if (we_i)                 m_busy[wa_i] = 1'b0;
            if (iss_i && ia_i != 5'd0) m_busy[ia_i] = 1'b1;
        end
        #1;
    endtask

    // Monitor: the outputs are combinational, so every cycle with a queued entry is checked.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("rd",          64'(bus.rd),          64'(e.rd));
            check("rd_busy",     64'(bus.rd_busy),     64'(e.rb));
            check("busy_cnt",    64'(bus.busy_cnt),    64'(e.cnt));
            check("rd_nobyp",    64'(bus_nb.rd),       64'(e.rd_nb));
            check("rd_busy_nb",  64'(bus_nb.rd_busy),  64'(e.rb_nb));
            check("busy_cnt_nb", 64'(bus_nb.busy_cnt), 64'(e.cnt));
        end
    end

    initial begin
        logic [4:0]  r_wa;
        logic [4:0]  r_ra0;
        logic [4:0]  r_ia;
        model_clear();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 1);

        cyc(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 5, 5, 0, 0, 1);
        cyc(0, 1, 0, 32'h1234, 0, 5, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 7, 0, 1, 7, 1);
        cyc(0, 0, 0, 0, 7, 7, 0, 0, 1);
        cyc(0, 1, 7, 32'h55, 7, 6, 0, 0, 1);
        cyc(0, 0, 0, 0, 7, 7, 0, 0, 1);
        cyc(0, 0, 0, 0, 3, 0, 1, 3, 1);
        cyc(0, 1, 3, 32'hA3, 3, 4, 1, 3, 1);
        cyc(0, 0, 0, 0, 3, 4, 0, 0, 1);
        cyc(0, 1, 3, 32'hB3, 6, 4, 1, 4, 1);
        cyc(0, 0, 0, 0, 3, 4, 0, 0, 1);
        for (int i = 1; i < 32; i++) cyc(0, 0, 0, 0, 5'(i), 5'(i - 1), 1, 5'(i), 1);
        cyc(0, 0, 0, 0, 9, 31, 1, 9, 1);
        cyc(1, 0, 0, 0, 2, 30, 1, 2, 1);
        cyc(0, 0, 0, 0, 2, 30, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            r_wa  = 5'($urandom_range(0, 31));
            r_ia  = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            r_ra0 = ($urandom_range(0, 3) == 0) ? r_wa : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0), r_wa, $urandom,
                r_ra0, 5'($urandom_range(0, 31)), ($urandom_range(0, 1) == 0), r_ia, 1);
        end

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
